// File: rtl/reg_dump_reader_if.sv
// reg_dump_reader_if: (index, data) beat stream leaving the register dump reader.
// master drives valid/idx/data/last and samples ready; slave is the consumer.
interface reg_dump_reader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_idx;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output out_valid,
    output out_idx,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_idx,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks register indices 0..NUM_REGS-1 through the register
// file read port and emits each value as an (index, data) beat.
// Ports: clk, rst (sync, active high), start, busy, done (1-cycle pulse),
//   rf_read_reg/rf_read_data (register file read port), beat_count,
//   dump (reg_dump_reader_if.master: out_valid/ready/idx/data/last).
// Option: define REG_DUMP_SKIP_ZERO_EN to drop beats for zero registers;
//   done is then the only reliable end-of-dump marker.
module reg_dump_reader #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_read_reg,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic [ADDR_W:0]   beat_count,
  reg_dump_reader_if.master dump
);

`ifdef REG_DUMP_SKIP_ZERO_EN
  localparam bit SKIP_ZERO = 1'b1;
`else
  localparam bit SKIP_ZERO = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND,
    FIN
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;

  // rf_read_reg is loaded with the next index on the
  // edge entering READ, so it equals ptr during READ.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      ptr            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      rf_read_reg    <= '0;
      beat_count     <= '0;
      dump.out_valid <= 1'b0;
      dump.out_idx   <= '0;
      dump.out_data  <= '0;
      dump.out_last  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            ptr         <= '0;
            beat_count  <= '0;
            rf_read_reg <= '0;
            busy        <= 1'b1;
            state       <= READ;
          end
        end
        READ: begin
          if (SKIP_ZERO && rf_read_data == '0) begin
            if (ptr == LAST) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              ptr         <= ptr + 1'b1;
              rf_read_reg <= ptr + 1'b1;
            end
          end else begin
            dump.out_idx   <= ptr;
            dump.out_data  <= rf_read_data;
            dump.out_valid <= 1'b1;
            dump.out_last  <= (ptr == LAST);
            state          <= SEND;
          end
        end
        SEND: begin
          if (dump.out_ready) begin
            dump.out_valid <= 1'b0;
            dump.out_last  <= 1'b0;
            beat_count     <= beat_count + 1'b1;
            if (ptr == LAST) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              ptr         <= ptr + 1'b1;
              rf_read_reg <= ptr + 1'b1;
              state       <= READ;
            end
          end
        end
        FIN: begin
          busy        <= 1'b0;
          rf_read_reg <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// tb_reg_dump_reader: scoreboard bench for reg_dump_reader; a model of the
// register file feeds an expected-beat queue checked by a monitor process.
module tb_reg_dump_reader;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic [4:0]  rf_read_reg;
  logic [31:0] rf_read_data;
  logic [5:0]  beat_count;
  logic [31:0] regs [N];

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t q[$];

  reg_dump_reader_if #(.ADDR_W(5), .DATA_W(32)) dif ();

  reg_dump_reader #(
    .NUM_REGS(N),
    .ADDR_W(5),
    .DATA_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .busy(busy),
    .done(done),
    .rf_read_reg(rf_read_reg),
    .rf_read_data(rf_read_data),
    .beat_count(beat_count),
    .dump(dif)
  );

  always #5 clk = ~clk;

  assign rf_read_data =
    (rf_read_reg == 5'd0) ? 32'd0 : regs[rf_read_reg];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Monitor: every presented beat must match the queue head;
  // it is popped only when the handshake completes.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && dif.out_valid) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_beat idx=%0d exp=none",
                   dif.out_idx);
        end else begin
          chk("beat_idx", 32'(dif.out_idx), 32'(q[0].idx));
          chk("beat_data", dif.out_data, q[0].data);
          chk("beat_last", 32'(dif.out_last), 32'(q[0].last));
          if (dif.out_ready) void'(q.pop_front());
        end
      end
    end
  end

  task automatic preload_ramp();
    for (int i = 0; i < N; i++) regs[i] = 32'(i * 16);
  endtask

  // Expected dump: each register as it is when read. A write issued
  // while beat j is on the bus is seen only by indices above j.
  task automatic run_dump(input int ready_pct,
                          input int wr_at,
                          input int wr_reg,
                          input logic [31:0] wr_val,
                          input int start_at,
                          input int rst_at,
                          input bit fin_start,
                          input bit chk_lat);
    int e = 0;
    int cyc;
    bit wrote = 0;
    bit injected = 0;
    logic [31:0] v;
    for (int k = 0; k < N; k++) begin
      v = (k == 0) ? 32'd0 : regs[k];
      if (wr_at >= 0 && k == wr_reg && k > wr_at) v = wr_val;
`ifdef REG_DUMP_SKIP_ZERO_EN
      if (v == 32'd0) continue;
`endif
      q.push_back('{idx: 5'(k), data: v, last: (k == N - 1)});
      e++;
    end
    @(posedge clk);
    #1 start = 1'b1;
    dif.out_ready = ($urandom_range(99) < 32'(ready_pct));
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 1;
    chk("busy_after_start", 32'(busy), 32'd1);
    while (!done) begin
      if (cyc > 3000) begin
        checks++;
        failures++;
        $display("FAIL done_timeout act=none exp=done");
        q.delete();
        return;
      end
      if (rst_at >= 0 && dif.out_valid &&
          int'(dif.out_idx) == rst_at) begin
        dif.out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_valid", 32'(dif.out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(beat_count), 32'd0);
        chk("rst_rdreg", 32'(rf_read_reg), 32'd0);
        q.delete();
        return;
      end
      if (wr_at >= 0 && !wrote && dif.out_valid &&
          int'(dif.out_idx) >= wr_at) begin
        regs[wr_reg] = wr_val;
        wrote = 1;
      end
      start = 1'b0;
      if (start_at >= 0 && !injected && dif.out_valid &&
          int'(dif.out_idx) == start_at) begin
        start = 1'b1;
        injected = 1;
      end
      dif.out_ready = ($urandom_range(99) < 32'(ready_pct));
      @(posedge clk);
      #1 cyc++;
    end
    start = 1'b0;
    if (chk_lat) chk("done_cycle", 32'(cyc), 32'(N + e + 1));
    chk("queue_empty", 32'(q.size()), 32'd0);
    chk("beat_count", 32'(beat_count), 32'(e));
    if (fin_start) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("done_pulse", 32'(done), 32'd0);
    chk("idle_valid", 32'(dif.out_valid), 32'd0);
    @(posedge clk);
    #1 chk("no_restart", 32'(busy), 32'd0);
    chk("count_hold", 32'(beat_count), 32'(e));
    q.delete();
  endtask

  initial begin
    dif.out_ready = 1'b0;
    for (int i = 0; i < N; i++) regs[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy0", 32'(busy), 32'd0);
    chk("rst_done0", 32'(done), 32'd0);
    chk("rst_valid0", 32'(dif.out_valid), 32'd0);
    chk("rst_idx0", 32'(dif.out_idx), 32'd0);
    chk("rst_data0", dif.out_data, 32'd0);
    chk("rst_last0", 32'(dif.out_last), 32'd0);
    chk("rst_rdreg0", 32'(rf_read_reg), 32'd0);
    chk("rst_count0", 32'(beat_count), 32'd0);
    rst = 1'b0;

    preload_ramp();
    run_dump(100, -1, 0, 0, -1, -1, 1, 1);
    preload_ramp();
    run_dump(33, -1, 0, 0, -1, -1, 0, 0);
    preload_ramp();
    run_dump(100, -1, 0, 0, 10, -1, 0, 1);
    preload_ramp();
    run_dump(100, -1, 0, 0, -1, 7, 0, 0);
    run_dump(100, -1, 0, 0, -1, -1, 0, 1);
    preload_ramp();
    run_dump(100, 5, 20, 32'hDEADBEEF, -1, -1, 0, 1);
    preload_ramp();
    run_dump(60, 25, 20, 32'hDEADBEEF, -1, -1, 0, 0);

    for (int i = 0; i < N; i++) regs[i] = '0;
    regs[3] = 32'h11;
    regs[31] = 32'h22;
    run_dump(100, -1, 0, 0, -1, -1, 0, 1);
    regs[31] = 32'h0;
    run_dump(100, -1, 0, 0, -1, -1, 0, 1);

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < N; i++)
        regs[i] = ($urandom_range(99) < 30) ? 32'd0 : $urandom;
      run_dump(int'($urandom_range(100, 20)),
               -1, 0, 0, -1, -1, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
